// File: rtl/voice_allocator_pkg.sv
// Shared constants for the voice allocator: FSM encoding and default widths.
package voice_allocator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    localparam int DEF_NOTE_W = 7;
    localparam int DEF_AGE_W  = 8;

endpackage

// File: rtl/voice_allocator_slot.sv
// One voice slot: sounding flag, note, velocity and a saturating age counter.
module voice_slot #(
    parameter int NOTE_W = 7,
    parameter int AGE_W  = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ld,
    input  logic              rtg,
    input  logic              rls,
    input  logic              inc,
    input  logic [NOTE_W-1:0] note_in,
    input  logic [NOTE_W-1:0] vel_in,
    output logic              active,
    output logic [NOTE_W-1:0] note,
    output logic [NOTE_W-1:0] vel,
    output logic [AGE_W-1:0]  age
);

    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
    localparam logic [AGE_W-1:0] AGE_ONE = {{(AGE_W-1){1'b0}}, 1'b1};

    // Slot state update; load beats retrigger beats release beats ageing.
    always_ff @(posedge clk) begin
        if (clr) begin
            active <= 1'b0;
            note   <= '0;
            vel    <= '0;
            age    <= '0;
        end else if (ld) begin
            active <= 1'b1;
            note   <= note_in;
            vel    <= vel_in;
            age    <= '0;
        end else if (rtg) begin
            vel    <= vel_in;
            age    <= '0;
        end else if (rls) begin
            active <= 1'b0;
            age    <= '0;
        end else if (inc && active) begin
            age    <= (age == AGE_MAX) ? age : age + AGE_ONE;
        end else begin
            age    <= active ? age : '0;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: accepts one note event per two cycles and
// maps it onto a voice slot (retrigger, free slot, or steal the oldest).
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = DEF_NOTE_W,
    parameter int AGE_W      = DEF_AGE_W
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_on,
    input  logic [NOTE_W-1:0]            ev_note,
    input  logic [NOTE_W-1:0]            ev_vel,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_vel,
    output logic [NUM_VOICES-1:0]        voice_trig,
    output logic [NUM_VOICES-1:0]        voice_rel
);

    localparam logic [NUM_VOICES-1:0] ONE_HOT0 = {{(NUM_VOICES-1){1'b0}}, 1'b1};

    state_t                state_r;
    logic                  on_r;
    logic [NOTE_W-1:0]     note_r;
    logic [NOTE_W-1:0]     vel_r;
    logic [NUM_VOICES-1:0] trig_r;
    logic [NUM_VOICES-1:0] rel_r;

    logic [NOTE_W-1:0]     note_s [NUM_VOICES];
    logic [NOTE_W-1:0]     vel_s  [NUM_VOICES];
    logic [AGE_W-1:0]      age_s  [NUM_VOICES];
    logic [NUM_VOICES-1:0] act_s;

    logic [NUM_VOICES-1:0] match_oh_s;
    logic                  match_found_s;
    logic [NUM_VOICES-1:0] free_oh_s;
    logic                  free_found_s;
    logic [NUM_VOICES-1:0] old_oh_s;
    logic [AGE_W-1:0]      best_age_s;
    logic [NUM_VOICES-1:0] ld_s;
    logic [NUM_VOICES-1:0] rtg_s;
    logic [NUM_VOICES-1:0] rls_s;
    logic [NUM_VOICES-1:0] inc_s;

    assign ev_ready     = (state_r == IDLE);
    assign voice_active = act_s;
    assign voice_trig   = trig_r;
    assign voice_rel    = rel_r;

    // Control FSM, event latch and registered trigger/release pulses.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= IDLE;
            on_r    <= 1'b0;
            note_r  <= '0;
            vel_r   <= '0;
            trig_r  <= '0;
            rel_r   <= '0;
        end else begin
            trig_r <= ld_s | rtg_s;
            rel_r  <= rls_s;
            case (state_r)
                IDLE: begin
                    if (ev_valid) begin
                        state_r <= EXEC;
                        on_r    <= ev_on && (ev_vel != '0);
                        note_r  <= ev_note;
                        vel_r   <= ev_vel;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Priority searches: lowest-index note match, lowest-index free slot,
    // and oldest active voice with ties resolved toward the lower index.
    always_comb begin
        match_oh_s    = '0;
        match_found_s = 1'b0;
        free_oh_s     = '0;
        free_found_s  = 1'b0;
        old_oh_s      = ONE_HOT0;
        best_age_s    = age_s[0];
        for (int i = 0; i < NUM_VOICES; i++) begin
            match_oh_s[i] = !match_found_s && act_s[i] && (note_s[i] == note_r);
            match_found_s = match_found_s || match_oh_s[i];
            free_oh_s[i]  = !free_found_s && !act_s[i];
            free_found_s  = free_found_s || free_oh_s[i];
        end
        for (int i = 1; i < NUM_VOICES; i++) begin
            old_oh_s   = (age_s[i] > best_age_s) ? (ONE_HOT0 << i) : old_oh_s;
            best_age_s = (age_s[i] > best_age_s) ? age_s[i] : best_age_s;
        end
    end

    // Per-slot control strobes for the executing event.
    always_comb begin
        ld_s  = '0;
        rtg_s = '0;
        rls_s = '0;
        if (state_r == EXEC) begin
            if (on_r) begin
                if (match_found_s) begin
                    rtg_s = match_oh_s;
                end else if (free_found_s) begin
                    ld_s = free_oh_s;
                end else begin
                    ld_s = old_oh_s;
                end
            end else begin
                rls_s = match_oh_s;
            end
        end else begin
            rls_s = '0;
        end
        inc_s = ((state_r == EXEC) && on_r) ? ~(ld_s | rtg_s) : '0;
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
        voice_slot #(
            .NOTE_W (NOTE_W),
            .AGE_W  (AGE_W)
        ) u_slot (
            .clk     (clk),
            .clr     (clr),
            .ld      (ld_s[g]),
            .rtg     (rtg_s[g]),
            .rls     (rls_s[g]),
            .inc     (inc_s[g]),
            .note_in (note_r),
            .vel_in  (vel_r),
            .active  (act_s[g]),
            .note    (note_s[g]),
            .vel     (vel_s[g]),
            .age     (age_s[g])
        );
        assign voice_note[g*NOTE_W +: NOTE_W] = note_s[g];
        assign voice_vel[g*NOTE_W +: NOTE_W]  = vel_s[g];
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: event-level reference model
// compared every cycle, plus literal expectations for the key scenarios.
module tb_voice_allocator;

    localparam int NV = 4;
    localparam int NW = 7;
    localparam int AGE_MAX = 255;

    logic              clk = 1'b0;
    logic              clr;
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_on;
    logic [NW-1:0]     ev_note;
    logic [NW-1:0]     ev_vel;
    logic [NV-1:0]     voice_active;
    logic [NV*NW-1:0]  voice_note;
    logic [NV*NW-1:0]  voice_vel;
    logic [NV-1:0]     voice_trig;
    logic [NV-1:0]     voice_rel;

    voice_allocator dut (
        .clk          (clk),
        .clr          (clr),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_on        (ev_on),
        .ev_note      (ev_note),
        .ev_vel       (ev_vel),
        .voice_active (voice_active),
        .voice_note   (voice_note),
        .voice_vel    (voice_vel),
        .voice_trig   (voice_trig),
        .voice_rel    (voice_rel)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [NV-1:0] m_act, m_trig, m_rel;
    logic [NW-1:0] m_note [NV];
    logic [NW-1:0] m_vel  [NV];
    int            m_age  [NV];
    logic          m_busy;
    logic          p_on;
    logic [NW-1:0] p_note, p_vel;

    int n_cmp = 0;
    int n_bad = 0;
    int dut_acc;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply_event();
        int hit, tgt;
        hit = -1;
        for (int i = NV - 1; i >= 0; i--)
            if (m_act[i] && m_note[i] == p_note) hit = i;
        if (p_on) begin
            if (hit >= 0) begin
                tgt = hit;
            end else begin
                tgt = -1;
                for (int i = NV - 1; i >= 0; i--)
                    if (!m_act[i]) tgt = i;
                if (tgt < 0) begin
                    tgt = 0;
                    for (int i = 1; i < NV; i++)
                        if (m_age[i] > m_age[tgt]) tgt = i;
                end
                m_note[tgt] = p_note;
            end
            for (int i = 0; i < NV; i++)
                if (m_act[i] && i != tgt && m_age[i] < AGE_MAX) m_age[i]++;
            m_act[tgt]  = 1'b1;
            m_vel[tgt]  = p_vel;
            m_age[tgt]  = 0;
            m_trig[tgt] = 1'b1;
        end else if (hit >= 0) begin
            m_act[hit] = 1'b0;
            m_age[hit] = 0;
            m_rel[hit] = 1'b1;
        end
    endtask

    task automatic model_edge(input logic c, input logic v, input logic o,
                              input logic [NW-1:0] n, input logic [NW-1:0] vl);
        if (c) begin
            m_act = '0; m_trig = '0; m_rel = '0; m_busy = 1'b0;
            for (int i = 0; i < NV; i++) begin
                m_note[i] = '0; m_vel[i] = '0; m_age[i] = 0;
            end
        end else begin
            m_trig = '0;
            m_rel  = '0;
            if (m_busy) begin
                apply_event();
                m_busy = 1'b0;
            end else if (v) begin
                m_busy = 1'b1;
                p_on   = o && (vl != '0);
                p_note = n;
                p_vel  = vl;
            end
        end
    endtask

    task automatic compare_all();
        logic [NV*NW-1:0] en, ev;
        for (int i = 0; i < NV; i++) begin
            en[i*NW +: NW] = m_note[i];
            ev[i*NW +: NW] = m_vel[i];
        end
        cmp("ready",  32'(ev_ready),     32'(!m_busy));
        cmp("active", 32'(voice_active), 32'(m_act));
        cmp("trig",   32'(voice_trig),   32'(m_trig));
        cmp("rel",    32'(voice_rel),    32'(m_rel));
        cmp("note",   32'(voice_note),   32'(en));
        cmp("vel",    32'(voice_vel),    32'(ev));
    endtask

    task automatic step(input logic c, input logic v, input logic o,
                        input logic [NW-1:0] n, input logic [NW-1:0] vl);
        clr = c; ev_valid = v; ev_on = o; ev_note = n; ev_vel = vl;
        if (!c && v && ev_ready) dut_acc++;
        @(posedge clk);
        model_edge(c, v, o, n, vl);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
    endtask

    task automatic rst();
        step(1'b1, 1'b0, 1'b0, 7'd0, 7'd0);
    endtask

    task automatic ev(input logic o, input logic [NW-1:0] n, input logic [NW-1:0] vl);
        step(1'b0, 1'b1, o, n, vl);
        idle();
    endtask

    initial begin
        dut_acc = 0;
        rst();
        rst();
        cmp("rst_active", 32'(voice_active), 32'h0);
        cmp("rst_ready",  32'(ev_ready),     32'h1);

        // single note-on
        step(1'b0, 1'b1, 1'b1, 7'd60, 7'd100);
        cmp("busy_ready", 32'(ev_ready), 32'h0);
        idle();
        cmp("on_active", 32'(voice_active),     32'b0001);
        cmp("on_note",   32'(voice_note[6:0]),  32'd60);
        cmp("on_vel",    32'(voice_vel[6:0]),   32'd100);
        cmp("on_trig",   32'(voice_trig),       32'b0001);
        idle();
        cmp("trig_drop", 32'(voice_trig), 32'h0);

        // fill, release middle, reuse freed slot
        rst();
        ev(1'b1, 7'd60, 7'd90); ev(1'b1, 7'd62, 7'd90);
        ev(1'b1, 7'd64, 7'd90); ev(1'b1, 7'd67, 7'd90);
        cmp("fill_active", 32'(voice_active), 32'b1111);
        ev(1'b0, 7'd62, 7'd0);
        cmp("off_active", 32'(voice_active), 32'b1101);
        cmp("off_rel",    32'(voice_rel),    32'b0010);
        ev(1'b1, 7'd70, 7'd80);
        cmp("reuse_note", 32'(voice_note[13:7]), 32'd70);
        cmp("reuse_trig", 32'(voice_trig),       32'b0010);

        // steal oldest
        rst();
        ev(1'b1, 7'd60, 7'd90); ev(1'b1, 7'd62, 7'd90);
        ev(1'b1, 7'd64, 7'd90); ev(1'b1, 7'd67, 7'd90);
        ev(1'b1, 7'd72, 7'd55);
        cmp("steal_trig", 32'(voice_trig),      32'b0001);
        cmp("steal_rel",  32'(voice_rel),       32'b0000);
        cmp("steal_note", 32'(voice_note[6:0]), 32'd72);

        // retrigger and velocity-zero release
        rst();
        ev(1'b1, 7'd60, 7'd100); ev(1'b1, 7'd62, 7'd50);
        ev(1'b1, 7'd60, 7'd20);
        cmp("rtg_trig", 32'(voice_trig),        32'b0001);
        cmp("rtg_vel0", 32'(voice_vel[6:0]),    32'd20);
        cmp("rtg_vel1", 32'(voice_vel[13:7]),   32'd50);
        ev(1'b1, 7'd60, 7'd0);
        cmp("v0_rel",    32'(voice_rel),    32'b0001);
        cmp("v0_active", 32'(voice_active), 32'b0010);

        // age saturation: voice0 ages past 255 while others are retriggered
        rst();
        ev(1'b1, 7'd60, 7'd90); ev(1'b1, 7'd62, 7'd90);
        ev(1'b1, 7'd64, 7'd90); ev(1'b1, 7'd67, 7'd90);
        for (int k = 0; k < 253; k++) begin
            case (k % 3)
                0:       ev(1'b1, 7'd62, 7'd40);
                1:       ev(1'b1, 7'd64, 7'd40);
                default: ev(1'b1, 7'd67, 7'd40);
            endcase
        end
        ev(1'b1, 7'd80, 7'd33);
        cmp("sat_trig", 32'(voice_trig),      32'b0001);
        cmp("sat_note", 32'(voice_note[6:0]), 32'd80);

        // back-to-back valid, inputs changing during EXEC
        rst();
        dut_acc = 0;
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, 1'b1, 7'(40 + i), 7'd64);
        idle();
        cmp("burst_acc", 32'(dut_acc), 32'd5);
        ev(1'b0, 7'd99, 7'd0);
        cmp("nohit_trig", 32'(voice_trig), 32'h0);
        cmp("nohit_rel",  32'(voice_rel),  32'h0);

        // clr during EXEC, and event alongside clr
        rst();
        step(1'b0, 1'b1, 1'b1, 7'd50, 7'd90);
        rst();
        cmp("clrx_active", 32'(voice_active), 32'h0);
        cmp("clrx_trig",   32'(voice_trig),   32'h0);
        cmp("clrx_ready",  32'(ev_ready),     32'h1);
        idle();
        cmp("clrx_trig2",  32'(voice_trig),   32'h0);
        step(1'b1, 1'b1, 1'b1, 7'd55, 7'd90);
        idle();
        cmp("clrev_ready",  32'(ev_ready),     32'h1);
        cmp("clrev_active", 32'(voice_active), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
